// File: rtl/riscv_ctl_pkg.sv
// riscv_ctl_pkg: opcode constants, sequencer state encoding and the NOP word shared by the decode-stage control
package riscv_ctl_pkg;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BCC   = 7'b1100011;
  localparam logic [6:0] LCC   = 7'b0000011;
  localparam logic [6:0] SCC   = 7'b0100011;
  localparam logic [6:0] MCC   = 7'b0010011;
  localparam logic [6:0] RCC   = 7'b0110011;
  localparam logic [6:0] MAC   = 7'b1111111;
  localparam logic [31:0] NOP  = 32'h00000013;
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MAC_BUSY = 2'd2} state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: operand-use decode of the IF/ID instruction and the load-use comparator against ID/EX
module hazard_detect
  import riscv_ctl_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_memread,
  output logic        o_lu_haz,
  output logic        o_is_mac
);
  logic [6:0] w_op;
  logic [4:0] w_rs1, w_rs2;
  logic       w_use_rs1, w_use_rs2, w_unused;
  assign w_op      = i_instr[6:0];
  assign w_rs1     = i_instr[19:15];
  assign w_rs2     = i_instr[24:20];
  assign w_unused  = ^{i_instr[31:25], i_instr[14:7]};
  assign w_use_rs1 = !(w_op == LUI || w_op == AUIPC || w_op == JAL);
  assign w_use_rs2 = w_op == RCC || w_op == SCC || w_op == BCC || w_op == MAC;
  assign o_is_mac  = w_op == MAC;
  assign o_lu_haz  = i_ex_memread && i_ex_rd != 5'd0 &&
                     ((w_use_rs1 && w_rs1 == i_ex_rd) || (w_use_rs2 && w_rs2 == i_ex_rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: IF/ID -> ID/EX sequencer for load-use stalls, branch flushes and multi-cycle MAC holds.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_count performance counters.
module pipe_hazard_ctrl
  import riscv_ctl_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int MAC_LAT    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instr,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        ex_hold,
  output logic [1:0]  busy_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);
  localparam logic [3:0] LU_CNT  = 4'(LU_BUBBLES > 1 ? LU_BUBBLES - 2 : 0);
  localparam logic [3:0] MAC_CNT = 4'(MAC_LAT - 2);
  if (LU_BUBBLES < 1 || LU_BUBBLES > 3) begin : g_bad_lu
    $error("pipe_hazard_ctrl: LU_BUBBLES must be 1..3");
  end
  if (MAC_LAT < 2 || MAC_LAT > 15) begin : g_bad_mac
    $error("pipe_hazard_ctrl: MAC_LAT must be 2..15");
  end
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_lu_haz, w_is_mac, w_run, w_flush, w_stall, w_hold;
  hazard_detect u_hd (
    .i_instr      (id_instr),
    .i_ex_rd      (ex_rd),
    .i_ex_memread (ex_memread),
    .o_lu_haz     (w_lu_haz),
    .o_is_mac     (w_is_mac)
  );
  // the unused encoding 3 behaves exactly like RUN
  assign w_run       = !(r_state == LU_STALL || r_state == MAC_BUSY);
  assign w_flush     = ex_br_taken && (w_run || r_state == LU_STALL);
  assign w_stall     = !w_flush && ((w_run && w_lu_haz) || r_state == LU_STALL);
  assign w_hold      = r_state == MAC_BUSY;
  assign pc_write    = !reset && !w_stall && !w_hold;
  assign ifid_write  = !reset && !w_stall && !w_hold;
  assign ifid_flush  = reset || w_flush;
  assign idex_bubble = reset || w_flush || w_stall;
  assign ex_hold     = !reset && w_hold;
  assign busy_state  = reset ? 2'd0 : r_state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else if (r_state == MAC_BUSY || (r_state == LU_STALL && !ex_br_taken)) begin
      r_state <= r_cnt == 4'd0 ? RUN : r_state;
      r_cnt   <= r_cnt == 4'd0 ? 4'd0 : r_cnt - 4'd1;
    end else if (ex_br_taken) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else if (w_lu_haz) begin
      r_state <= LU_BUBBLES > 1 ? LU_STALL : RUN;
      r_cnt   <= LU_CNT;
    end else if (w_is_mac) begin
      r_state <= MAC_BUSY;
      r_cnt   <= MAC_CNT;
    end else begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles, r_flush_count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      r_stall_cycles <= r_stall_cycles + {31'd0, !pc_write};
      r_flush_count  <= r_flush_count + {31'd0, ifid_flush};
    end
  end
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench driving two sequencers (LU_BUBBLES=1 and 3) with shared directed stimulus
module tb_pipe_hazard_ctrl;
  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_ADD  = 32'h006283B3;
  localparam logic [31:0] I_LUI  = 32'h000282B7;
  localparam logic [31:0] I_ADDI = 32'h00628393;
  localparam logic [31:0] I_MAC  = 32'h0062837F;
  localparam logic [6:0] E_RST = 7'b0011000;
  localparam logic [6:0] E_RUN = 7'b1100000;
  localparam logic [6:0] E_FL0 = 7'b1011000;
  localparam logic [6:0] E_FL1 = 7'b1011001;
  localparam logic [6:0] E_LUR = 7'b0001000;
  localparam logic [6:0] E_LUS = 7'b0001001;
  localparam logic [6:0] E_MB  = 7'b0000110;
  localparam logic [6:0] M_ALL = 7'b1111111;
  localparam logic [6:0] M_FL  = 7'b1011111;
  typedef struct {
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] m;
    string      n;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] id_instr = 32'h00000013;
  logic [4:0] ex_rd = 5'd0;
  logic ex_memread = 1'b0, ex_br_taken = 1'b0;
  logic pcw_a, ifw_a, fl_a, bub_a, hold_a, pcw_b, ifw_b, fl_b, bub_b, hold_b;
  logic [1:0] st_a, st_b;
  logic [6:0] got_a, got_b;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
  int exp_sc_a = 0, exp_fc_a = 0, exp_sc_b = 0, exp_fc_b = 0;
`endif
  always #5 clk = ~clk;
  assign got_a = {pcw_a, ifw_a, fl_a, bub_a, hold_a, st_a};
  assign got_b = {pcw_b, ifw_b, fl_b, bub_b, hold_b, st_b};
  pipe_hazard_ctrl #(.LU_BUBBLES(1), .MAC_LAT(3)) u_a (
    .clk(clk), .reset(reset), .id_instr(id_instr), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .pc_write(pcw_a), .ifid_write(ifw_a), .ifid_flush(fl_a),
    .idex_bubble(bub_a), .ex_hold(hold_a), .busy_state(st_a)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc_a), .flush_count(fc_a)
`endif
  );
  pipe_hazard_ctrl #(.LU_BUBBLES(3), .MAC_LAT(3)) u_b (
    .clk(clk), .reset(reset), .id_instr(id_instr), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .pc_write(pcw_b), .ifid_write(ifw_b), .ifid_flush(fl_b),
    .idex_bubble(bub_b), .ex_hold(hold_b), .busy_state(st_b)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc_b), .flush_count(fc_b)
`endif
  );
  // monitor: outputs are valid every cycle, so one expected entry is consumed per falling edge
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp += 2;
      if ((got_a & e.m) !== (e.a & e.m)) begin
        n_bad++;
        $display("FAIL %s lu1: got {pcw,ifw,fl,bub,hold,st}=%b want %b (mask %b)", e.n, got_a, e.a, e.m);
      end
      if ((got_b & e.m) !== (e.b & e.m)) begin
        n_bad++;
        $display("FAIL %s lu3: got {pcw,ifw,fl,bub,hold,st}=%b want %b (mask %b)", e.n, got_b, e.b, e.m);
      end
    end
  end
  task automatic step(input logic [31:0] ins, input logic [4:0] rd, input logic mr, input logic br,
                      input logic rs, input logic [6:0] ea, input logic [6:0] eb, input string nm);
    @(posedge clk);
    #1;
    id_instr = ins;
    ex_rd = rd;
    ex_memread = mr;
    ex_br_taken = br;
    reset = rs;
    q.push_back('{ea, eb, (ea[4] | eb[4]) ? M_FL : M_ALL, nm});
`ifdef HAZARD_PERF_EN
    if (rs) begin
      exp_sc_a = 0; exp_fc_a = 0; exp_sc_b = 0; exp_fc_b = 0;
    end else begin
      exp_sc_a += int'(!ea[6]); exp_fc_a += int'(ea[4]);
      exp_sc_b += int'(!eb[6]); exp_fc_b += int'(eb[4]);
    end
`endif
  endtask
  initial begin
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b1, E_RST, E_RST, "reset");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "reset_run");
    step(I_ADD,  5'd5, 1'b1, 1'b0, 1'b0, E_LUR, E_LUR, "lu_first");
    step(I_ADD,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_LUS, "lu_second");
    step(I_ADD,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_LUS, "lu_third");
    step(I_ADD,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "lu_done");
    step(I_ADD,  5'd0, 1'b1, 1'b0, 1'b0, E_RUN, E_RUN, "rd_zero");
    step(I_LUI,  5'd5, 1'b1, 1'b0, 1'b0, E_RUN, E_RUN, "lui_no_rs1");
    step(I_ADDI, 5'd6, 1'b1, 1'b0, 1'b0, E_RUN, E_RUN, "itype_no_rs2");
    step(I_ADDI, 5'd5, 1'b1, 1'b0, 1'b0, E_LUR, E_LUR, "itype_rs1_haz");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_LUS, "itype_stall2");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_LUS, "itype_stall3");
    step(I_ADD,  5'd6, 1'b1, 1'b0, 1'b0, E_LUR, E_LUR, "rs2_haz");
    step(I_ADD,  5'd0, 1'b0, 1'b1, 1'b0, E_FL0, E_FL1, "stall_abort");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "after_abort");
    step(I_ADD,  5'd5, 1'b1, 1'b1, 1'b0, E_FL0, E_FL0, "flush_priority");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "flush_stays_run");
    step(I_MAC,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "mac_issue");
    step(I_NOP,  5'd0, 1'b0, 1'b1, 1'b0, E_MB,  E_MB,  "mac_busy1_br");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b0, E_MB,  E_MB,  "mac_busy2");
    step(I_MAC,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "mac2_issue");
    step(I_MAC,  5'd0, 1'b0, 1'b0, 1'b0, E_MB,  E_MB,  "mac2_busy1");
    step(I_MAC,  5'd0, 1'b0, 1'b0, 1'b0, E_MB,  E_MB,  "mac2_busy2");
    step(I_MAC,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "mac3_issue");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b1, E_RST, E_RST, "reset_mid_mac");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b1, E_RST, E_RST, "reset_hold");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "reset_release");
    step(I_ADD,  5'd5, 1'b1, 1'b0, 1'b0, E_LUR, E_LUR, "perf_stall");
    step(I_NOP,  5'd0, 1'b0, 1'b1, 1'b0, E_FL0, E_FL1, "perf_flush");
    step(I_NOP,  5'd0, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN, "final_run");
    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_EN
    n_cmp += 4;
    if (sc_a !== 32'(exp_sc_a)) begin n_bad++; $display("FAIL stall_cycles lu1: got %0d want %0d", sc_a, exp_sc_a); end
    if (fc_a !== 32'(exp_fc_a)) begin n_bad++; $display("FAIL flush_count lu1: got %0d want %0d", fc_a, exp_fc_a); end
    if (sc_b !== 32'(exp_sc_b)) begin n_bad++; $display("FAIL stall_cycles lu3: got %0d want %0d", sc_b, exp_sc_b); end
    if (fc_b !== 32'(exp_fc_b)) begin n_bad++; $display("FAIL flush_count lu3: got %0d want %0d", fc_b, exp_fc_b); end
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
